// File: rtl/mmu_tlb_if.sv
// mmu_tlb_if: lookup request/response handshake bundle between address generation (master) and mmu_tlb (slave)
interface mmu_tlb_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_uncached;
  logic        resp_refill;
  logic        resp_invalid;
  logic        resp_modify;
  modport master (
    output req_valid, req_vaddr, req_store, resp_ready,
    input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_refill, resp_invalid, resp_modify
  );
  modport slave (
    input  req_valid, req_vaddr, req_store, resp_ready,
    output req_ready, resp_valid, resp_paddr, resp_uncached, resp_refill, resp_invalid, resp_modify
  );
endinterface

// File: rtl/mmu_tlb.sv
// mmu_tlb: kseg0/kseg1 fixed translation plus fully associative software-managed TLB for mapped segments
// Ports: clk, rst (sync, active-high); bus = lookup handshake (mmu_tlb_if.slave);
//   cur_asid = current ASID; wr_en/wr_index/wr_entry = TLB write; probe_en -> probe_hit/probe_index next cycle.
// wr_entry = {vpn2[18:0],asid[7:0],g,pfn0[19:0],c0[2:0],d0,v0,pfn1[19:0],c1[2:0],d1,v1}
// Macro MMU_TLB_EN: when undefined there is no TLB; mapped segments pass through with no faults.
module mmu_tlb #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int ASID_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  mmu_tlb_if.slave          bus,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [77:0]       wr_entry,
  input  logic              probe_en,
  output logic              probe_hit,
  output logic [IDX_W-1:0]  probe_index
);
  typedef struct packed {
    logic        valid;
    logic [31:0] paddr;
    logic        unc;
    logic        refill;
    logic        invalid;
    logic        modify;
  } resp_t;
  resp_t       resp_q, resp_d, look;
  logic [31:0] va;
  logic        unmapped;
  assign va       = bus.req_vaddr;
  assign unmapped = va[31:30] == 2'b10;
`ifdef MMU_TLB_EN
  logic [77:0]     tlb_q [TLB_ENTRIES];
  logic [77:0]     tlb_d [TLB_ENTRIES];
  logic [IDX_W:0]  lk;
  logic [24:0]     half;
  logic            fault;
  logic            probe_hit_q, probe_hit_d;
  logic [IDX_W-1:0] probe_index_q, probe_index_d;
  // Returns {hit, index}; scanning downward lets the lowest matching index win.
  function automatic logic [IDX_W:0] find(input logic [18:0] vpn2, input logic [ASID_W-1:0] asid);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--)
      if (tlb_q[i][77:59] == vpn2 && (tlb_q[i][50] || tlb_q[i][51 +: ASID_W] == asid))
        r = {1'b1, IDX_W'(i)};
    return r;
  endfunction
  always_comb begin
    tlb_d = tlb_q;
    if (wr_en) tlb_d[wr_index] = wr_entry;
    {probe_hit_d, probe_index_d} = probe_en ? find(wr_entry[77:59], wr_entry[51 +: ASID_W])
                                            : {probe_hit_q, probe_index_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tlb_q         <= '{default: '0};
      probe_hit_q   <= 1'b0;
      probe_index_q <= '0;
    end else begin
      tlb_q         <= tlb_d;
      probe_hit_q   <= probe_hit_d;
      probe_index_q <= probe_index_d;
    end
  end
  assign probe_hit   = probe_hit_q;
  assign probe_index = probe_index_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{bus.req_store, cur_asid, wr_en, wr_index, wr_entry, probe_en};
  assign probe_hit     = 1'b0;
  assign probe_index   = '0;
`endif
  always_comb begin
    look       = '0;
    look.valid = 1'b1;
    look.paddr = unmapped ? {va[31:28] & 4'h1, va[27:0]} : va;
    look.unc   = unmapped & va[29];
`ifdef MMU_TLB_EN
    lk    = find(va[31:13], cur_asid);
    // half = {pfn[19:0], c[2:0], d, v} of the odd (vaddr[12]=1) or even page
    half  = va[12] ? tlb_q[lk[IDX_W-1:0]][24:0] : tlb_q[lk[IDX_W-1:0]][49:25];
    fault = ~lk[IDX_W] | ~half[0] | (bus.req_store & ~half[1]);
    if (!unmapped) begin
      look.refill  = ~lk[IDX_W];
      look.invalid = lk[IDX_W] & ~half[0];
      look.modify  = lk[IDX_W] & half[0] & ~half[1] & bus.req_store;
      look.paddr   = fault ? va : {half[24:5], va[11:0]};
      look.unc     = ~fault & (half[4:2] == 3'd2);
    end
`endif
  end
  assign bus.req_ready = ~resp_q.valid | bus.resp_ready;
  always_comb begin
    resp_d = resp_q;
    if (bus.req_valid && bus.req_ready) resp_d = look;
    else if (bus.resp_ready) resp_d.valid = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) resp_q <= '0;
    else resp_q <= resp_d;
  end
  assign bus.resp_valid    = resp_q.valid;
  assign bus.resp_paddr    = resp_q.paddr;
  assign bus.resp_uncached = resp_q.unc;
  assign bus.resp_refill   = resp_q.refill;
  assign bus.resp_invalid  = resp_q.invalid;
  assign bus.resp_modify   = resp_q.modify;
endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed self-checking bench for mmu_tlb (expectations follow MMU_TLB_EN)
module tb_mmu_tlb;
`ifdef MMU_TLB_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cur_asid = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_index = '0;
  logic [77:0] wr_entry = '0;
  logic        probe_en = 1'b0;
  logic        probe_hit;
  logic [3:0]  probe_index;
  int          total = 0;
  int          bad = 0;
  logic [31:0] pa;
  logic        unc, rf, inv, md, vld;
  mmu_tlb_if bus();
  mmu_tlb dut (
    .clk(clk), .rst(rst), .bus(bus), .cur_asid(cur_asid),
    .wr_en(wr_en), .wr_index(wr_index), .wr_entry(wr_entry),
    .probe_en(probe_en), .probe_hit(probe_hit), .probe_index(probe_index)
  );
  always #5 clk = ~clk;
  function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                     input logic [19:0] p0, input logic [2:0] c0, input logic d0, input logic v0,
                                     input logic [19:0] p1, input logic [2:0] c1, input logic d1, input logic v1);
    return {vpn2, asid, g, p0, c0, d0, v0, p1, c1, d1, v1};
  endfunction
  task automatic sample();
    pa = bus.resp_paddr; unc = bus.resp_uncached; rf = bus.resp_refill;
    inv = bus.resp_invalid; md = bus.resp_modify; vld = bus.resp_valid;
  endtask
  task automatic lookup(input logic [31:0] a, input logic st, input logic [7:0] asid);
    cur_asid = asid; bus.req_vaddr = a; bus.req_store = st; bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    sample();
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [3:0] idx, input logic [77:0] e);
    wr_en = 1'b1; wr_index = idx; wr_entry = e;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask
  task automatic probe(input logic [77:0] e);
    probe_en = 1'b1; wr_entry = e;
    @(posedge clk); #1;
    probe_en = 1'b0;
  endtask
  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.req_store = 1'b0; bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.resp_valid); end
    total++; if (bus.resp_paddr !== 32'h0) begin bad++; $display("FAIL reset_paddr got %h want 0", bus.resp_paddr); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    total++; if ({probe_hit, probe_index} !== 5'h0) begin bad++; $display("FAIL reset_probe got %b/%h want 0/0", probe_hit, probe_index); end
  endtask
  task automatic test_unmapped();
    lookup(32'h9FC0_0100, 1'b0, 8'd0);
    total++; if ({vld, pa, unc} !== {1'b1, 32'h1FC0_0100, 1'b0}) begin bad++; $display("FAIL kseg0 got v%b %h u%b want v1 1fc00100 u0", vld, pa, unc); end
    lookup(32'hBFC0_0000, 1'b1, 8'd0);
    total++; if ({vld, pa, unc, rf, inv, md} !== {1'b1, 32'h1FC0_0000, 4'b1000}) begin bad++; $display("FAIL kseg1 got v%b %h u%b f%b%b%b want v1 1fc00000 u1 f000", vld, pa, unc, rf, inv, md); end
    lookup(32'h8000_1234, 1'b0, 8'd0);
    total++; if ({pa, unc} !== {32'h0000_1234, 1'b0}) begin bad++; $display("FAIL kseg0_low got %h u%b want 00001234 u0", pa, unc); end
  endtask
  task automatic test_mapped();
    wr(4'd3, mk(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    lookup(32'h0040_0ABC, 1'b0, 8'd5);
    total++; if ({vld, pa, unc, rf, inv, md} !== {1'b1, EN ? 32'h1234_5ABC : 32'h0040_0ABC, 4'b0000}) begin bad++; $display("FAIL map_hit got v%b %h u%b f%b%b%b", vld, pa, unc, rf, inv, md); end
    lookup(32'h0040_0ABC, 1'b0, 8'd6);
    total++; if ({pa, unc, rf, inv, md} !== {32'h0040_0ABC, 1'b0, EN, 2'b00}) begin bad++; $display("FAIL map_asid_refill got %h u%b f%b%b%b want refill=%b", pa, unc, rf, inv, md, EN); end
    wr(4'd1, mk(19'h00300, 8'd9, 1'b1, 20'h00077, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    lookup(32'h0060_0123, 1'b1, 8'h22);
    total++; if ({pa, rf, inv, md} !== {EN ? 32'h0007_7123 : 32'h0060_0123, 3'b000}) begin bad++; $display("FAIL map_global got %h f%b%b%b", pa, rf, inv, md); end
  endtask
  task automatic test_faults();
    lookup(32'h0040_1ABC, 1'b0, 8'd5);
    total++; if ({pa, unc, rf, inv, md} !== {32'h0040_1ABC, 1'b0, 1'b0, EN, 1'b0}) begin bad++; $display("FAIL odd_invalid got %h u%b f%b%b%b want invalid=%b", pa, unc, rf, inv, md, EN); end
    wr(4'd3, mk(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b1));
    lookup(32'h0040_1000, 1'b1, 8'd5);
    total++; if ({pa, unc, rf, inv, md} !== {32'h0040_1000, 1'b0, 2'b00, EN}) begin bad++; $display("FAIL store_modify got %h u%b f%b%b%b want modify=%b", pa, unc, rf, inv, md, EN); end
    lookup(32'h0040_1000, 1'b0, 8'd5);
    total++; if ({pa, unc, rf, inv, md} !== {EN ? 32'h5432_1000 : 32'h0040_1000, EN, 3'b000}) begin bad++; $display("FAIL load_odd got %h u%b f%b%b%b", pa, unc, rf, inv, md); end
  endtask
  task automatic test_probe();
    probe(mk(19'h00200, 8'd5, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0));
    total++; if ({probe_hit, probe_index} !== {EN, EN ? 4'd3 : 4'd0}) begin bad++; $display("FAIL probe_hit got %b/%0d want %b/%0d", probe_hit, probe_index, EN, EN ? 3 : 0); end
    probe(mk(19'h00200, 8'd7, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0));
    total++; if ({probe_hit, probe_index} !== 5'h0) begin bad++; $display("FAIL probe_miss got %b/%0d want 0/0", probe_hit, probe_index); end
    wr_en = 1'b1; wr_index = 4'd5;
    probe(mk(19'h00500, 8'd5, 1'b0, 20'h11111, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    wr_en = 1'b0;
    total++; if (probe_hit !== 1'b0) begin bad++; $display("FAIL probe_same_cycle_write got %b want 0", probe_hit); end
    probe(mk(19'h00500, 8'd5, 1'b0, 20'h11111, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    total++; if ({probe_hit, probe_index} !== {EN, EN ? 4'd5 : 4'd0}) begin bad++; $display("FAIL probe_after_write got %b/%0d want %b/%0d", probe_hit, probe_index, EN, EN ? 5 : 0); end
  endtask
  task automatic test_write_lookup();
    wr_en = 1'b1; wr_index = 4'd3;
    wr_entry = mk(19'h00200, 8'd5, 1'b0, 20'h0BEEF, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b1);
    cur_asid = 8'd5; bus.req_vaddr = 32'h0040_0ABC; bus.req_store = 1'b0; bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; bus.req_valid = 1'b0;
    sample();
    @(posedge clk); #1;
    total++; if (pa !== (EN ? 32'h1234_5ABC : 32'h0040_0ABC)) begin bad++; $display("FAIL write_lookup_old got %h", pa); end
    lookup(32'h0040_0ABC, 1'b0, 8'd5);
    total++; if (pa !== (EN ? 32'h0BEE_FABC : 32'h0040_0ABC)) begin bad++; $display("FAIL write_lookup_new got %h", pa); end
  endtask
  task automatic test_multihit();
    wr(4'd0, mk(19'h00200, 8'd5, 1'b0, 20'hAAAAA, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    lookup(32'h0040_0ABC, 1'b0, 8'd5);
    total++; if ({pa, rf, inv, md} !== {EN ? 32'hAAAA_AABC : 32'h0040_0ABC, 3'b000}) begin bad++; $display("FAIL multihit_lowest got %h f%b%b%b", pa, rf, inv, md); end
  endtask
  task automatic test_back_to_back();
    bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_vaddr = 32'h9000_0010;
    @(posedge clk); #1;
    total++; if ({bus.resp_valid, bus.resp_paddr} !== {1'b1, 32'h1000_0010}) begin bad++; $display("FAIL bp_first got v%b %h want v1 10000010", bus.resp_valid, bus.resp_paddr); end
    bus.req_vaddr = 32'hA000_0020;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if ({bus.req_ready, bus.resp_valid, bus.resp_paddr, bus.resp_uncached} !== {2'b01, 32'h1000_0010, 1'b0}) begin bad++; $display("FAIL bp_hold%0d got r%b v%b %h u%b want r0 v1 10000010 u0", i, bus.req_ready, bus.resp_valid, bus.resp_paddr, bus.resp_uncached); end
    end
    bus.resp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
    total++; if ({bus.resp_valid, bus.resp_paddr, bus.resp_uncached} !== {1'b1, 32'h0000_0020, 1'b1}) begin bad++; $display("FAIL b2b_second got v%b %h u%b want v1 00000020 u1", bus.resp_valid, bus.resp_paddr, bus.resp_uncached); end
    bus.req_vaddr = 32'h8000_0030;
    @(posedge clk); #1;
    total++; if ({bus.resp_valid, bus.resp_paddr, bus.resp_uncached} !== {1'b1, 32'h0000_0030, 1'b0}) begin bad++; $display("FAIL b2b_third got v%b %h u%b want v1 00000030 u0", bus.resp_valid, bus.resp_paddr, bus.resp_uncached); end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b want 0", bus.resp_valid); end
  endtask
  task automatic test_reset_mid();
    cur_asid = 8'd5; bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_vaddr = 32'h0040_0ABC;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pending got %b want 1", bus.resp_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_dropped got %b want 0", bus.resp_valid); end
    lookup(32'h0040_0ABC, 1'b0, 8'd5);
    total++; if ({pa, unc, rf, inv, md} !== {32'h0040_0ABC, 1'b0, EN, 2'b00}) begin bad++; $display("FAIL rstmid_refill got %h u%b f%b%b%b want refill=%b", pa, unc, rf, inv, md, EN); end
    probe(mk(19'h00200, 8'd5, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0));
    total++; if (probe_hit !== 1'b0) begin bad++; $display("FAIL rstmid_probe got %b want 0", probe_hit); end
  endtask
  initial begin
    test_reset();
    test_unmapped();
    test_mapped();
    test_faults();
    test_probe();
    test_write_lookup();
    test_multihit();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
